draw_rect_ctl: RTL and testbench
================================

Name: draw_rect_ctl

Overview:
- Position controller for the rectangle drawer. It produces the rectangle's top-left corner (xpos, ypos) and sequences it per frame.
- Idle mode: the rectangle tracks the mouse.
- A left-button press drops it under constant gravity; it bounces on the screen floor with halved speed until it comes to rest.
- Sits between the mouse interface and the rectangle drawer. Motion updates once per frame on the rising edge of vertical blanking.

Parameters:
- SCREEN_HEIGHT, 600, visible lines.
- RECT_HEIGHT, 64, rectangle height in px. Floor position FLOOR = SCREEN_HEIGHT - RECT_HEIGHT.
- GRAVITY, 1, velocity increment per frame (px/frame).
- DAMP_SHIFT, 1, bounce velocity = impact velocity >> DAMP_SHIFT.
- VEL_MAX, 255, downward velocity saturation (px/frame).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- mouse_left  in  1  left button level
- mouse_xpos  in  12  mouse x
- mouse_ypos  in  12  mouse y
- vblnk  in  1  vertical blanking from the timing bus
- xpos  out  12  rectangle x (registered)
- ypos  out  12  rectangle y (registered)
- busy  out  1  high in FALL or RISE (registered)

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=FOLLOW; xpos=0, ypos=0, vel=0, busy=0; edge detector registers cleared to 0.
- Edge detection:
  - press = mouse_left & ~mouse_left_d.
  - tick = vblnk & ~vblnk_d.
  - Both delay registers update every cycle.
- Internal velocity vel: 12-bit unsigned. Sums are computed 13-bit before compare/clamp; no wrap-around permitted.
- FOLLOW:
  - Every cycle xpos<=mouse_xpos, ypos<=mouse_ypos (1-cycle latency).
  - On press: xpos/ypos hold their current values, vel<=0, go to FALL.
  - press has priority over tick in the same cycle; that tick is ignored.
- FALL, on tick:
  - v = min(vel+GRAVITY, VEL_MAX); y = ypos+v.
  - If y >= FLOOR: ypos<=FLOOR, b = v>>DAMP_SHIFT. If b==0, vel<=0 and go to STOP; else vel<=b and go to RISE.
  - Otherwise ypos<=y, vel<=v.
- RISE, on tick:
  - ypos <= (ypos>=vel) ? ypos-vel : 0.
  - If vel<=GRAVITY or ypos<=vel: vel<=0, go to FALL. Otherwise vel<=vel-GRAVITY.
- STOP: position held, vel=0. On press, go to FOLLOW; tracking begins the next cycle.
- Non-tick cycles in FALL/RISE/STOP: xpos, ypos, vel unchanged.
- press while in FALL/RISE is ignored.
- xpos is frozen from entry to FALL until return to FOLLOW.
- Mouse y already >= FLOOR at press: the first tick clamps ypos to FLOOR and applies bounce.
- busy = 1 iff the registered state is FALL or RISE; it updates in the same cycle as the state register.

Test Plan:
- Reset/follow: assert rst 3 cycles with mouse (100,200) -> xpos=ypos=0, busy=0. Release rst -> xpos=100, ypos=200 one cycle later; change mouse to (101,201) -> outputs follow with 1-cycle latency.
- Drop and settle (defaults, FLOOR=536): press at mouse (300,530), then 5 vblnk rising edges:
  - ypos sequence 531, 533, 536 (bounce, vel=1, RISE), 535 (vel=0, FALL), 536 (b=0, STOP).
  - busy falls on tick 5; xpos stays 300 throughout.
- Tick gating: hold vblnk high 1000 cycles during FALL -> exactly one update. Toggling mouse_left in FALL -> no effect.
- Simultaneous press and vblnk rising edge in FOLLOW at ypos=100 -> state FALL, ypos stays 100 until the next tick, then 101.
- Saturation: VEL_MAX=4, press at y=0 -> ypos 1, 3, 6, 10, 14, 18 (vel capped at 4).
- Reset mid-fall after 2 ticks -> next cycle xpos=ypos=0, busy=0, FOLLOW. Following press/ticks restart from vel=0.

Source files
------------

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: the rectangle tracks the mouse, and a left
// click drops it under gravity. It bounces off the floor until it comes to rest.
module draw_rect_ctl #(
  parameter int SCREEN_HEIGHT = 600,
  parameter int RECT_HEIGHT   = 64,
  parameter int GRAVITY       = 1,
  parameter int DAMP_SHIFT    = 1,
  parameter int VEL_MAX       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam logic [12:0] FLOOR = 13'(SCREEN_HEIGHT - RECT_HEIGHT);
  localparam logic [12:0] GRAV  = 13'(GRAVITY);
  localparam logic [12:0] VMAX  = 13'(VEL_MAX);

  typedef enum logic [1:0] {FOLLOW, FALL, RISE, STOP} state_t;

  state_t      state, state_nxt;
  logic [11:0] vel, vel_nxt, xpos_nxt, ypos_nxt;
  logic        mouse_left_d, vblnk_d;
  logic        press, tick;

  logic [12:0] v_sum, y_sum;
  logic [11:0] v_sat, bounce;

  assign press = mouse_left & ~mouse_left_d;
  assign tick  = vblnk & ~vblnk_d;

  // The falling-step arithmetic is done at 13 bits, so it cannot wrap before the clamp.
  assign v_sum  = {1'b0, vel} + GRAV;
  assign v_sat  = (v_sum > VMAX) ? VMAX[11:0] : v_sum[11:0];
  assign y_sum  = {1'b0, ypos} + {1'b0, v_sat};
  assign bounce = v_sat >> DAMP_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FOLLOW;
      xpos         <= '0;
      ypos         <= '0;
      vel          <= '0;
      busy         <= 1'b0;
      mouse_left_d <= 1'b0;
      vblnk_d      <= 1'b0;
    end else begin
      state        <= state_nxt;
      xpos         <= xpos_nxt;
      ypos         <= ypos_nxt;
      vel          <= vel_nxt;
      busy         <= (state_nxt == FALL) || (state_nxt == RISE);
      mouse_left_d <= mouse_left;
      vblnk_d      <= vblnk;
    end
  end

  always_comb begin
    state_nxt = state;
    xpos_nxt  = xpos;
    ypos_nxt  = ypos;
    vel_nxt   = vel;
    case (state)
      FOLLOW: begin
        if (press) begin
          vel_nxt   = '0;
          state_nxt = FALL;
        end else begin
          xpos_nxt = mouse_xpos;
          ypos_nxt = mouse_ypos;
        end
      end
      FALL: begin
        if (tick) begin
          if (y_sum >= FLOOR) begin
            ypos_nxt = FLOOR[11:0];
            if (bounce == '0) begin
              vel_nxt   = '0;
              state_nxt = STOP;
            end else begin
              vel_nxt   = bounce;
              state_nxt = RISE;
            end
          end else begin
            ypos_nxt = y_sum[11:0];
            vel_nxt  = v_sat;
          end
        end
      end
      RISE: begin
        if (tick) begin
          ypos_nxt = (ypos >= vel) ? ypos - vel : '0;
          if (({1'b0, vel} <= GRAV) || (ypos <= vel)) begin
            vel_nxt   = '0;
            state_nxt = FALL;
          end else begin
            vel_nxt = vel - GRAV[11:0];
          end
        end
      end
      STOP: begin
        if (press) state_nxt = FOLLOW;
      end
      default: state_nxt = FOLLOW;
    endcase
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl. The stimulus queues the expected outputs,
// and a negedge monitor pops them and checks them against the DUTs.
module tb_draw_rect_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_left = 1'b0, vblnk = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic        busy;

  logic        mouse_left2 = 1'b0, vblnk2 = 1'b0;
  logic [11:0] mouse_xpos2 = '0, mouse_ypos2 = '0;
  logic [11:0] xpos2, ypos2;
  logic        busy2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [11:0] x;
    logic [11:0] y;
    logic        b;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  draw_rect_ctl dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos), .vblnk(vblnk), .xpos(xpos), .ypos(ypos), .busy(busy)
  );

  draw_rect_ctl #(.VEL_MAX(4)) dut_sat (
    .clk(clk), .rst(rst), .mouse_left(mouse_left2), .mouse_xpos(mouse_xpos2),
    .mouse_ypos(mouse_ypos2), .vblnk(vblnk2), .xpos(xpos2), .ypos(ypos2), .busy(busy2)
  );

  // Monitor: an entry pushed just after an active edge is compared at the next negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [11:0] ax, ay;
      logic        ab;
      e  = exp_q.pop_front();
      ax = (e.id == 0) ? xpos : xpos2;
      ay = (e.id == 0) ? ypos : ypos2;
      ab = (e.id == 0) ? busy : busy2;
      checks++;
      if (ax !== e.x || ay !== e.y || ab !== e.b) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d busy=%0d, expected x=%0d y=%0d busy=%0d",
                 e.name, ax, ay, ab, e.x, e.y, e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int id, input int x, input int y, input logic b,
                            input string name);
    exp_t e;
    e.id = id; e.x = 12'(x); e.y = 12'(y); e.b = b; e.name = name;
    exp_q.push_back(e);
  endtask

  // Rising edge of vblnk, then it is dropped. The check applies to the update edge.
  task automatic tick1(input int x, input int y, input logic b, input string name);
    vblnk = 1'b1;
    step();
    expect_out(0, x, y, b, name);
    vblnk = 1'b0;
    step();
  endtask

  task automatic press1();
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
  endtask

  initial begin
    // Reset and follow
    mouse_xpos = 12'd100; mouse_ypos = 12'd200;
    rst = 1'b1;
    step(); step(); step();
    expect_out(0, 0, 0, 1'b0, "reset_state");
    rst = 1'b0;
    step();
    expect_out(0, 100, 200, 1'b0, "follow_first");
    mouse_xpos = 12'd101; mouse_ypos = 12'd201;
    step();
    expect_out(0, 101, 201, 1'b0, "follow_latency");

    // Drop from 530 and settle on the floor at 536
    mouse_xpos = 12'd300; mouse_ypos = 12'd530;
    step();
    expect_out(0, 300, 530, 1'b0, "follow_pre_drop");
    press1();
    expect_out(0, 300, 530, 1'b1, "press_holds");
    mouse_xpos = 12'd50; mouse_ypos = 12'd50;
    step();
    expect_out(0, 300, 530, 1'b1, "fall_no_tick");
    tick1(300, 531, 1'b1, "drop_t1");
    tick1(300, 533, 1'b1, "drop_t2");
    tick1(300, 536, 1'b1, "drop_t3_bounce");
    tick1(300, 535, 1'b1, "drop_t4_rise");
    tick1(300, 536, 1'b0, "drop_t5_stop");

    // STOP: a press returns the block to FOLLOW, and tracking starts one cycle later
    press1();
    expect_out(0, 300, 536, 1'b0, "stop_press_hold");
    step();
    expect_out(0, 50, 50, 1'b0, "stop_to_follow");

    // Tick gating: a long vblnk gives one update, and clicks during the fall are ignored
    mouse_xpos = 12'd20; mouse_ypos = 12'd100;
    step();
    expect_out(0, 20, 100, 1'b0, "follow_100");
    press1();
    step();
    vblnk = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      mouse_left = ~mouse_left;
      step();
    end
    mouse_left = 1'b0;
    expect_out(0, 20, 101, 1'b1, "long_vblnk_one_update");
    vblnk = 1'b0;
    step();
    expect_out(0, 20, 101, 1'b1, "vblnk_fall_no_update");
    tick1(20, 103, 1'b1, "fall_103");
    tick1(20, 106, 1'b1, "fall_106");

    // Reset while the rectangle is falling
    rst = 1'b1;
    step();
    expect_out(0, 0, 0, 1'b0, "reset_mid_fall");
    rst = 1'b0;
    step();
    expect_out(0, 20, 100, 1'b0, "follow_after_reset");

    // A press and a vblnk edge in the same cycle: the press wins and the tick is dropped
    mouse_left = 1'b1; vblnk = 1'b1;
    step();
    expect_out(0, 20, 100, 1'b1, "press_and_tick");
    mouse_left = 1'b0; vblnk = 1'b0;
    step();
    expect_out(0, 20, 100, 1'b1, "press_tick_hold");
    tick1(20, 101, 1'b1, "restart_vel0");
    tick1(20, 103, 1'b1, "restart_vel1");

    // Mouse already below the floor at the press: clamp to the floor, then stop
    rst = 1'b1;
    step();
    rst = 1'b0;
    mouse_xpos = 12'd5; mouse_ypos = 12'd590;
    step();
    expect_out(0, 5, 590, 1'b0, "follow_below_floor");
    press1();
    step();
    tick1(5, 536, 1'b0, "below_floor_clamp_stop");

    // Velocity saturation on the VEL_MAX=4 instance
    mouse_xpos2 = 12'd7; mouse_ypos2 = 12'd0;
    step();
    expect_out(1, 7, 0, 1'b0, "sat_follow");
    mouse_left2 = 1'b1;
    step();
    mouse_left2 = 1'b0;
    step();
    begin
      int ys[6] = '{1, 3, 6, 10, 14, 18};
      for (int i = 0; i < 6; i++) begin
        vblnk2 = 1'b1;
        step();
        expect_out(1, 7, ys[i], 1'b1, $sformatf("sat_t%0d", i + 1));
        vblnk2 = 1'b0;
        step();
      end
    end

    step(); step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
